fifo_flag_monitor: RTL and testbench
====================================

FIFO_FLAG_MONITOR -- requirements
Module: fifo_flag_monitor

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries, power of two, >= 4.
REQ-002 Parameter AF_THRESH, default DEPTH-2: almost_full asserts when occupancy >= AF_THRESH.
REQ-003 Parameter AE_THRESH, default 2: almost_empty asserts when occupancy <= AE_THRESH.
REQ-004 Parameter SYNC_STAGES, default 2: pointer synchroniser depth; SHALL equal the monitored FIFO's value.
REQ-005 wclk  in  1  write clock.
REQ-006 wrst_n  in  1  reset, asynchronous, active-low, write domain.
REQ-007 rclk  in  1  read clock.
REQ-008 rrst_n  in  1  asynchronous active-low reset, read domain.
REQ-009 wenable, full, almost_full, werr_clr  in  1 each  write-domain observed/control inputs.
REQ-010 renable, empty, almost_empty, rerr_clr  in  1 each  read-domain observed/control inputs.
REQ-011 werr  out  4  sticky write-domain errors: [0] overflow, [1] full mismatch, [2] almost_full mismatch, [3] full&&empty.
REQ-012 rerr  out  4  sticky read-domain errors: [0] underflow, [1] empty mismatch, [2] almost_empty mismatch, [3] full&&empty.
REQ-013 werr_cnt, rerr_cnt  out  16 each  violation-cycle counters, in their own domains.
REQ-014 wocc, rocc  out  $clog2(DEPTH)+1 each  monitor occupancy in each domain.

Function
REQ-015 The write pointer SHALL be a $clog2(DEPTH)+1-bit binary count, incremented on each wclk edge with wenable && !full.
REQ-016 The read pointer SHALL increment on each rclk edge with renable && !empty.
REQ-017 Each pointer SHALL cross domains as Gray code through SYNC_STAGES flops and be converted back to binary.
REQ-018 wocc SHALL equal wptr minus the synced rptr, modulo 2^($clog2(DEPTH)+1); rocc SHALL equal synced wptr minus rptr.
REQ-019 Pointer wrap-around SHALL be handled by the extra MSB: occupancy DEPTH is distinct from 0.
REQ-020 werr[0] SHALL set when a write is accepted while wocc == DEPTH.
REQ-021 werr[1] SHALL set when full != (wocc == DEPTH).
REQ-022 werr[2] SHALL set when almost_full != (wocc >= AF_THRESH).
REQ-023 werr[3] SHALL set when full && empty is sampled on wclk; rerr[3] is the same check sampled on rclk.
REQ-024 rerr[0] SHALL set when a read is accepted while rocc == 0.
REQ-025 rerr[1] SHALL set when empty != (rocc == 0).
REQ-026 rerr[2] SHALL set when almost_empty != (rocc <= AE_THRESH).
REQ-027 Checks SHALL use the registered values from the current edge; error bits SHALL appear one clock after the violating edge.
REQ-028 Error bits SHALL be sticky until the same-domain clear; if a clear and a violation occur in the same cycle, the violation SHALL win.
REQ-029 Each counter SHALL increment by 1 per clock in which any of its domain's error conditions holds, and SHALL saturate at 16'hFFFF.
REQ-030 err_clr SHALL NOT clear the counters; only reset clears them.
REQ-031 Checks SHALL be suppressed for SYNC_STAGES+1 clocks after release of the domain's own reset.

Reset
REQ-032 wrst_n low SHALL immediately clear wptr, the rptr synchroniser, wocc, werr and werr_cnt.
REQ-033 rrst_n low SHALL immediately clear rptr, the wptr synchroniser, rocc, rerr and rerr_cnt.
REQ-034 Reset of one domain mid-operation SHALL NOT touch the other domain's state; any resulting mismatches SHALL be reported as errors.

Structure
REQ-035 Package fifo_mon_pkg SHALL hold the error-bit index constants, the bin2gray/gray2bin functions and the counter width constant.
REQ-036 Sub-module gray_ptr_sync (bin to Gray, SYNC_STAGES flops, Gray to bin) SHALL be instantiated once per crossing direction.

Verification (DEPTH=8, SYNC_STAGES=2)
REQ-037 Both resets, 8 writes, no reads, full asserted on the 8th accept -> wocc=8, werr=0, werr_cnt=0.
REQ-038 Forced full=0 with wocc=8 and wenable=1 -> werr=4'b0011 next wclk, werr_cnt=1.
REQ-039 Forced empty=0 with rocc=0 and renable=1 -> rerr=4'b0011, rerr_cnt=1.
REQ-040 full=empty=1 held for one cycle of each clock -> werr[3]=1 and rerr[3]=1.
REQ-041 werr_clr pulsed in the same cycle as a new overflow -> werr[0] stays 1 and werr_cnt increments.
REQ-042 wrst_n pulsed with 5 entries held -> werr/werr_cnt/wocc=0 immediately; after 3 wclks, a full/almost_full mismatch is reported against the unreset read side.

Source files
------------

// File: rtl/fifo_mon_pkg.sv
// Shared constants and Gray-code helpers for the FIFO flag monitor.
// Error bit layout is the same in both domains; only bit meanings differ (overflow/underflow etc.).
package fifo_mon_pkg;

  localparam int CNT_W  = 16;
  localparam int ERR_W  = 4;
  localparam int GRAY_W = 32;

  localparam int ERR_XFLOW  = 0;  // overflow (write side) / underflow (read side)
  localparam int ERR_FLAG   = 1;  // full / empty mismatch
  localparam int ERR_ALMOST = 2;  // almost_full / almost_empty mismatch
  localparam int ERR_BOTH   = 3;  // full && empty

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Carries a binary pointer across clock domains: registered Gray copy in the source
// domain, SYNC_STAGES flops in the destination domain, then back to binary.
module gray_ptr_sync
  import fifo_mon_pkg::*;
#(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         src_clk,
  input  logic         src_rst_n,
  input  logic [W-1:0] src_bin_next,
  input  logic         dst_clk,
  input  logic         dst_rst_n,
  output logic [W-1:0] dst_bin
);

  logic [W-1:0]                  src_gray;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  // Gray is registered from the next-state pointer so it always equals bin2gray(ptr)
  // with no extra latency and never glitches on multi-bit binary changes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) src_gray <= '0;
    else            src_gray <= W'(bin2gray(GRAY_W'(src_bin_next)));
  end

  // NOTE: the synchroniser chain is reset so occupancy is defined immediately after reset.
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= src_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign dst_bin = W'(gray2bin(GRAY_W'(sync_q[SYNC_STAGES-1])));

endmodule

// File: rtl/fifo_flag_monitor.sv
// Shadow-pointer monitor for an async FIFO: rebuilds occupancy in each domain and
// flags overflow/underflow and status-flag mismatches with sticky bits and counters.
module fifo_flag_monitor
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int AE_THRESH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   wenable,
  input  logic                   full,
  input  logic                   almost_full,
  input  logic                   werr_clr,
  input  logic                   renable,
  input  logic                   empty,
  input  logic                   almost_empty,
  input  logic                   rerr_clr,
  output logic [ERR_W-1:0]       werr,
  output logic [ERR_W-1:0]       rerr,
  output logic [CNT_W-1:0]       werr_cnt,
  output logic [CNT_W-1:0]       rerr_cnt,
  output logic [$clog2(DEPTH):0] wocc,
  output logic [$clog2(DEPTH):0] rocc
);

  localparam int              PW       = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]   OCC_FULL = PW'(DEPTH);
  localparam logic [PW-1:0]   OCC_AF   = PW'(AF_THRESH);
  localparam logic [PW-1:0]   OCC_AE   = PW'(AE_THRESH);
  localparam int              SUP_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [SUP_W-1:0] SUP_DONE = SUP_W'(SYNC_STAGES + 1);

  logic [PW-1:0]    wptr, wptr_next, rptr_wsync;
  logic [PW-1:0]    rptr, rptr_next, wptr_rsync;
  logic             w_accept, r_accept;
  logic [SUP_W-1:0] w_sup, r_sup;
  logic [ERR_W-1:0] w_viol, r_viol;

  assign w_accept  = wenable && !full;
  assign r_accept  = renable && !empty;
  assign wptr_next = wptr + PW'(w_accept);
  assign rptr_next = rptr + PW'(r_accept);

  // The extra pointer MSB makes the modular difference distinguish DEPTH from 0.
  assign wocc = wptr - rptr_wsync;
  assign rocc = wptr_rsync - rptr;

  gray_ptr_sync #(.W(PW), .SYNC_STAGES(SYNC_STAGES)) u_wptr_sync (
    .src_clk      (wclk),
    .src_rst_n    (wrst_n),
    .src_bin_next (wptr_next),
    .dst_clk      (rclk),
    .dst_rst_n    (rrst_n),
    .dst_bin      (wptr_rsync)
  );

  gray_ptr_sync #(.W(PW), .SYNC_STAGES(SYNC_STAGES)) u_rptr_sync (
    .src_clk      (rclk),
    .src_rst_n    (rrst_n),
    .src_bin_next (rptr_next),
    .dst_clk      (wclk),
    .dst_rst_n    (wrst_n),
    .dst_bin      (rptr_wsync)
  );

  // Write domain: pointer, post-reset blanking window, checks, sticky errors, counter.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr  <= '0;
      w_sup <= '0;
    end else begin
      wptr <= wptr_next;
      if (w_sup != SUP_DONE) w_sup <= w_sup + SUP_W'(1);
    end
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    w_viol = '0;
    if (w_sup == SUP_DONE) begin
      w_viol[ERR_XFLOW]  = w_accept && (wocc == OCC_FULL);
      w_viol[ERR_FLAG]   = full != (wocc == OCC_FULL);
      w_viol[ERR_ALMOST] = almost_full != (wocc >= OCC_AF);
      w_viol[ERR_BOTH]   = full && empty;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      werr     <= '0;
      werr_cnt <= '0;
    end else begin
      werr <= (werr & ~{ERR_W{werr_clr}}) | w_viol;
      if ((|w_viol) && (werr_cnt != '1)) werr_cnt <= werr_cnt + CNT_W'(1);
    end
  end

  // Read domain mirrors the write domain with underflow/empty/almost_empty checks.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr  <= '0;
      r_sup <= '0;
    end else begin
      rptr <= rptr_next;
      if (r_sup != SUP_DONE) r_sup <= r_sup + SUP_W'(1);
    end
  end

  always_comb begin
    r_viol = '0;
    if (r_sup == SUP_DONE) begin
      r_viol[ERR_XFLOW]  = r_accept && (rocc == '0);
      r_viol[ERR_FLAG]   = empty != (rocc == '0);
      r_viol[ERR_ALMOST] = almost_empty != (rocc <= OCC_AE);
      r_viol[ERR_BOTH]   = full && empty;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rerr     <= '0;
      rerr_cnt <= '0;
    end else begin
      rerr <= (rerr & ~{ERR_W{rerr_clr}}) | r_viol;
      if ((|r_viol) && (rerr_cnt != '1)) rerr_cnt <= rerr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_flag_monitor.sv
// Directed bench for fifo_flag_monitor (DEPTH=8, SYNC_STAGES=2); write-side stimulus
// changes on negedge wclk, read-side on negedge rclk, so no input moves on an active edge.
module tb_fifo_flag_monitor;

  logic        wclk = 1'b0, rclk = 1'b0;
  logic        wrst_n, rrst_n;
  logic        wenable, full, almost_full, werr_clr;
  logic        renable, empty, almost_empty, rerr_clr;
  logic [3:0]  werr, rerr;
  logic [15:0] werr_cnt, rerr_cnt;
  logic [3:0]  wocc, rocc;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;
  always #7 rclk = ~rclk;

  fifo_flag_monitor #(.DEPTH(8), .SYNC_STAGES(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .wenable      (wenable),
    .full         (full),
    .almost_full  (almost_full),
    .werr_clr     (werr_clr),
    .renable      (renable),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rerr_clr     (rerr_clr),
    .werr         (werr),
    .rerr         (rerr),
    .werr_cnt     (werr_cnt),
    .rerr_cnt     (rerr_cnt),
    .wocc         (wocc),
    .rocc         (rocc)
  );

  task automatic set_idle();
    wenable = 0; renable = 0; full = 0; almost_full = 0;
    empty = 1; almost_empty = 1; werr_clr = 0; rerr_clr = 0;
  endtask

  task automatic do_reset();
    set_idle();
    @(negedge wclk);
    wrst_n = 0; rrst_n = 0;
    repeat (2) @(negedge wclk);
    wrst_n = 1; rrst_n = 1;
    repeat (6) @(negedge wclk);
  endtask

  task automatic test_reset();
    set_idle();
    wrst_n = 0; rrst_n = 0;
    #3;
    checks++; if (werr !== 4'b0000) begin errors++; $display("FAIL reset_werr: got %b expected 0000", werr); end
    checks++; if (rerr !== 4'b0000) begin errors++; $display("FAIL reset_rerr: got %b expected 0000", rerr); end
    checks++; if (werr_cnt !== 16'd0) begin errors++; $display("FAIL reset_werr_cnt: got %0d expected 0", werr_cnt); end
    checks++; if (rerr_cnt !== 16'd0) begin errors++; $display("FAIL reset_rerr_cnt: got %0d expected 0", rerr_cnt); end
    checks++; if (wocc !== 4'd0) begin errors++; $display("FAIL reset_wocc: got %0d expected 0", wocc); end
    checks++; if (rocc !== 4'd0) begin errors++; $display("FAIL reset_rocc: got %0d expected 0", rocc); end
  endtask

  // Eight clean writes with correctly driven flags; read side only counts occupancy here.
  task automatic test_fill();
    int occ = 0;
    do_reset();
    @(negedge wclk) empty = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wclk);
      wenable = 1; full = (occ == 8); almost_full = (occ >= 6);
      @(posedge wclk);
      occ++;
      #1;
      if (occ == 6) begin
        checks++; if (wocc !== 4'd6) begin errors++; $display("FAIL fill_wocc6: got %0d expected 6", wocc); end
      end
    end
    @(negedge wclk);
    wenable = 0; full = 1; almost_full = 1;
    @(posedge wclk); #1;
    checks++; if (wocc !== 4'd8) begin errors++; $display("FAIL fill_wocc8: got %0d expected 8", wocc); end
    checks++; if (werr !== 4'b0000) begin errors++; $display("FAIL fill_werr: got %b expected 0000", werr); end
    checks++; if (werr_cnt !== 16'd0) begin errors++; $display("FAIL fill_werr_cnt: got %0d expected 0", werr_cnt); end
    repeat (4) @(posedge rclk); #1;
    checks++; if (rocc !== 4'd8) begin errors++; $display("FAIL fill_rocc: got %0d expected 8", rocc); end
  endtask

  // full wrongly low at occupancy 8 with a write: overflow plus full mismatch.
  task automatic test_overflow();
    @(negedge wclk);
    full = 0; wenable = 1;
    @(posedge wclk); #1;
    checks++; if (werr !== 4'b0011) begin errors++; $display("FAIL ovf_werr: got %b expected 0011", werr); end
    checks++; if (werr_cnt !== 16'd1) begin errors++; $display("FAIL ovf_werr_cnt: got %0d expected 1", werr_cnt); end
    @(negedge wclk) wenable = 0;  // occupancy now 9: full=0, almost_full=1 are consistent
    repeat (3) @(posedge wclk); #1;
    checks++; if (werr !== 4'b0011) begin errors++; $display("FAIL ovf_sticky_werr: got %b expected 0011", werr); end
    checks++; if (werr_cnt !== 16'd1) begin errors++; $display("FAIL ovf_sticky_cnt: got %0d expected 1", werr_cnt); end
    checks++; if (wocc !== 4'd9) begin errors++; $display("FAIL ovf_wocc: got %0d expected 9", wocc); end
  endtask

  // Wrap the 4-bit pointer back to occupancy 8, then overflow again while clearing.
  task automatic test_clr_overflow();
    int occ = 9;
    for (int i = 0; i < 15; i++) begin
      @(negedge wclk);
      wenable = 1; full = 0; almost_full = (occ >= 6);
      @(posedge wclk);
      occ = (occ + 1) % 16;
    end
    @(negedge wclk);
    wenable = 1; full = 0; almost_full = 1; werr_clr = 1;
    @(posedge wclk); #1;
    checks++; if (werr !== 4'b0011) begin errors++; $display("FAIL clr_ovf_werr: got %b expected 0011", werr); end
    checks++; if (werr_cnt !== 16'd2) begin errors++; $display("FAIL clr_ovf_cnt: got %0d expected 2", werr_cnt); end
    @(negedge wclk) wenable = 0;
    @(posedge wclk); #1;
    checks++; if (werr !== 4'b0000) begin errors++; $display("FAIL clr_only_werr: got %b expected 0000", werr); end
    checks++; if (werr_cnt !== 16'd2) begin errors++; $display("FAIL clr_only_cnt: got %0d expected 2", werr_cnt); end
    @(negedge wclk) werr_clr = 0;
  endtask

  task automatic test_underflow();
    do_reset();
    @(negedge rclk);
    renable = 1; empty = 0; almost_empty = 1;
    @(posedge rclk); #1;
    checks++; if (rerr !== 4'b0011) begin errors++; $display("FAIL udf_rerr: got %b expected 0011", rerr); end
    checks++; if (rerr_cnt !== 16'd1) begin errors++; $display("FAIL udf_rerr_cnt: got %0d expected 1", rerr_cnt); end
    @(negedge rclk);
    renable = 0; almost_empty = 0;  // occupancy now 15: empty=0, almost_empty=0 consistent
    repeat (3) @(posedge rclk); #1;
    checks++; if (rerr !== 4'b0011) begin errors++; $display("FAIL udf_sticky_rerr: got %b expected 0011", rerr); end
    checks++; if (rerr_cnt !== 16'd1) begin errors++; $display("FAIL udf_sticky_cnt: got %0d expected 1", rerr_cnt); end
    checks++; if (rocc !== 4'd15) begin errors++; $display("FAIL udf_rocc: got %0d expected 15", rocc); end
  endtask

  task automatic test_full_and_empty();
    do_reset();
    @(negedge wclk) full = 1;
    fork
      @(posedge wclk);
      @(posedge rclk);
    join
    @(negedge wclk) full = 0;
    #1;
    checks++; if (werr !== 4'b1010) begin errors++; $display("FAIL fe_werr: got %b expected 1010", werr); end
    checks++; if (rerr !== 4'b1000) begin errors++; $display("FAIL fe_rerr: got %b expected 1000", rerr); end
  endtask

  // 7 writes, 2 reads -> 5 held; write-side reset then resyncs against rptr=2.
  task automatic test_wreset_midop();
    do_reset();
    @(negedge wclk) empty = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge wclk) wenable = 1;
    end
    @(negedge wclk) wenable = 0;
    @(negedge rclk) renable = 1;
    repeat (2) @(negedge rclk);
    renable = 0;
    repeat (8) @(negedge wclk);
    checks++; if (wocc !== 4'd5) begin errors++; $display("FAIL wrst_pre_wocc: got %0d expected 5", wocc); end
    checks++; if (werr !== 4'b0100) begin errors++; $display("FAIL wrst_pre_werr: got %b expected 0100", werr); end
    wrst_n = 0;
    #1;
    checks++; if (werr !== 4'b0000) begin errors++; $display("FAIL wrst_werr: got %b expected 0000", werr); end
    checks++; if (werr_cnt !== 16'd0) begin errors++; $display("FAIL wrst_cnt: got %0d expected 0", werr_cnt); end
    checks++; if (wocc !== 4'd0) begin errors++; $display("FAIL wrst_wocc: got %0d expected 0", wocc); end
    @(negedge wclk) wrst_n = 1;
    repeat (3) @(posedge wclk); #1;
    checks++; if (werr !== 4'b0000) begin errors++; $display("FAIL wrst_blank_werr: got %b expected 0000", werr); end
    checks++; if (werr_cnt !== 16'd0) begin errors++; $display("FAIL wrst_blank_cnt: got %0d expected 0", werr_cnt); end
    @(posedge wclk); #1;
    checks++; if (werr !== 4'b0100) begin errors++; $display("FAIL wrst_post_werr: got %b expected 0100", werr); end
    checks++; if (werr_cnt !== 16'd1) begin errors++; $display("FAIL wrst_post_cnt: got %0d expected 1", werr_cnt); end
    checks++; if (wocc !== 4'd14) begin errors++; $display("FAIL wrst_post_wocc: got %0d expected 14", wocc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_clr_overflow();
    test_underflow();
    test_full_and_empty();
    test_wreset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
